// File: rtl/bcd_input_loader_pkg.sv
// bcd_input_loader_pkg: shared sizes, sign limits and FSM encoding for the BCD keypad loader.
package bcd_input_loader_pkg;
    localparam int NUM_SLOTS  = 7;
    localparam int MAX_DIGITS = 3;
    localparam int MAG_W      = 10;
    localparam int POS_MAX    = 127;
    localparam int NEG_MAX    = 128;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_input_loader_digit_acc.sv
// bcd_digit_accumulator: decimal magnitude builder (mag*10+digit) with digit count and overflow detect.
module bcd_digit_accumulator
    import bcd_input_loader_pkg::*;
#(
    parameter int MAX_DIGITS = bcd_input_loader_pkg::MAX_DIGITS
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clr,
    input  logic             load,
    input  logic [3:0]       digit,
    output logic [MAG_W-1:0] mag,
    output logic             accept,
    output logic             reject
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [CNT_W-1:0] cnt;
    logic             full;

    assign full   = cnt == CNT_W'(MAX_DIGITS);
    assign accept = load && digit <= 4'd9 && !full;
    assign reject = load && !accept;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mag <= '0;
            cnt <= '0;
        end else if (clr) begin
            mag <= '0;
            cnt <= '0;
        end else if (accept) begin
            mag <= MAG_W'(32'(mag) * 10 + 32'(digit));
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bcd_input_loader.sv
// bcd_input_loader: keypad-driven loader of signed decimal entries into seven 8-bit input slots.
module bcd_input_loader
    import bcd_input_loader_pkg::*;
#(
    parameter int NUM_SLOTS  = bcd_input_loader_pkg::NUM_SLOTS,
    parameter int MAX_DIGITS = bcd_input_loader_pkg::MAX_DIGITS
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    input  logic             sign_toggle,
    input  logic             enter,
    input  logic             clear,
    output logic [7:0]       indata1,
    output logic [7:0]       indata2,
    output logic [7:0]       indata3,
    output logic [7:0]       indata4,
    output logic [7:0]       indata5,
    output logic [7:0]       indata6,
    output logic [7:0]       indata7,
    output logic [2:0]       slot_idx,
    output logic [MAG_W-1:0] entry_mag,
    output logic             entry_neg,
    output logic             error,
    output logic             done
);
    state_t     state;
    logic [7:0] slots [7];
    logic       active, svc_enter, svc_digit, svc_sign;
    logic       acc_accept, acc_reject, mag_legal;
    logic [7:0] commit_val;

    // One strobe per cycle: clear > enter > digit_valid > sign_toggle; DONE ignores all but clear.
    assign active    = state != S_DONE;
    assign svc_enter = !clear && enter && active;
    assign svc_digit = !clear && !enter && digit_valid && active;
    assign svc_sign  = !clear && !enter && !digit_valid && sign_toggle && active;

    assign mag_legal  = entry_neg ? entry_mag <= MAG_W'(NEG_MAX) : entry_mag <= MAG_W'(POS_MAX);
    assign commit_val = entry_neg ? 8'(-entry_mag[7:0]) : entry_mag[7:0];

    bcd_digit_accumulator #(.MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clk    (clk),
        .resetN (resetN),
        .clr    (clear || svc_enter),
        .load   (svc_digit),
        .digit  (digit_in),
        .mag    (entry_mag),
        .accept (acc_accept),
        .reject (acc_reject)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            slot_idx  <= '0;
            entry_neg <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 7; i++) slots[i] <= '0;
        end else if (clear) begin
            state     <= S_IDLE;
            slot_idx  <= '0;
            entry_neg <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 7; i++) slots[i] <= '0;
        end else if (svc_enter) begin
            entry_neg <= 1'b0;
            state     <= S_IDLE;
            if (!mag_legal) begin
                error <= 1'b1;
            end else begin
                slots[slot_idx] <= commit_val;
                if (slot_idx == 3'(NUM_SLOTS - 1)) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    slot_idx <= 3'd7;
                end else begin
                    slot_idx <= slot_idx + 3'd1;
                end
            end
        end else if (svc_digit) begin
            if (acc_reject) error <= 1'b1;
            if (acc_accept) state <= S_ENTRY;
        end else if (svc_sign) begin
            entry_neg <= !entry_neg;
        end
    end

    assign indata1 = slots[0];
    assign indata2 = slots[1];
    assign indata3 = slots[2];
    assign indata4 = slots[3];
    assign indata5 = slots[4];
    assign indata6 = slots[5];
    assign indata7 = slots[6];
endmodule

// File: doc/bcd_input_loader.md
BCD_INPUT_LOADER -- requirements
Module: bcd_input_loader

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 7, the number of 8-bit memory-mapped input slots.
REQ-002 SHALL have parameter MAX_DIGITS, default 3, the number of decimal digits accepted per entry.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and resetN.
REQ-004 SHALL have port clk, input, 1 bit: the system clock, rising edge.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port digit_in, input, 4 bits: the BCD key value.
REQ-007 SHALL have port digit_valid, input, 1 bit: a one-cycle strobe that qualifies digit_in.
REQ-008 SHALL have port sign_toggle, input, 1 bit: a one-cycle strobe that inverts the sign of the current entry.
REQ-009 SHALL have port enter, input, 1 bit: a one-cycle strobe that commits the current entry to the current slot.
REQ-010 SHALL have port clear, input, 1 bit: a one-cycle strobe that performs a synchronous full clear.
REQ-011 SHALL have ports indata1..indata7, output, 8 bits each: registered two's-complement slot values that feed the processor input map.
REQ-012 SHALL have port slot_idx, output, 3 bits: the index of the slot being entered (0..6), or 7 when done.
REQ-013 SHALL have port entry_mag, output, 10 bits: the accumulated magnitude, for display preview.
REQ-014 SHALL have port entry_neg, output, 1 bit: the sign of the current entry.
REQ-015 SHALL have port error, output, 1 bit: a sticky entry-error flag.
REQ-016 SHALL have port done, output, 1 bit: high when all slots are loaded.

Function
REQ-017 SHALL implement the FSM states IDLE (no digits yet), ENTRY (1..MAX_DIGITS digits held) and DONE.
REQ-018 SHALL service only one strobe per cycle, in the priority clear > enter > digit_valid > sign_toggle, and drop lower-priority strobes in that cycle.
REQ-019 SHALL, on digit_valid with digit_in <= 9 and digit count < MAX_DIGITS, set entry_mag = entry_mag*10 + digit_in, increment the digit count and move IDLE->ENTRY.
REQ-020 SHALL, on digit_valid with digit_in > 9, ignore the digit and set error.
REQ-021 SHALL, on digit_valid when the digit count == MAX_DIGITS, ignore the digit and set error, leaving entry_mag unchanged.
REQ-022 SHALL, on sign_toggle in IDLE or ENTRY, invert entry_neg.
REQ-023 SHALL accept on enter only the legal range: magnitude 0..127 when positive, 0..128 when negative.
REQ-024 SHALL, on a legal enter, write slot[slot_idx] = entry_neg ? -entry_mag : entry_mag (8-bit two's complement), increment slot_idx, clear entry_mag, entry_neg and the digit count, and go to IDLE.
REQ-025 SHALL make the slot write visible on indataN in the cycle after enter is sampled, i.e. one-cycle latency.
REQ-026 SHALL, on enter in IDLE, commit value 0 (-0 gives 0x00).
REQ-027 SHALL, on an illegal enter, set error, leave the slot and slot_idx unchanged, discard the entry and go to IDLE.
REQ-028 SHALL, when the NUM_SLOTS-th commit occurs, go to DONE, set done=1 and set slot_idx=7.
REQ-029 SHALL ignore digit_valid, sign_toggle and enter while in DONE.
REQ-030 SHALL, on clear, zero all slots, slot_idx, entry_mag, entry_neg, error and done, and go to IDLE, in any state.
REQ-031 SHALL hold error until clear or reset; a legal enter does not clear it.

Reset
REQ-032 SHALL, while resetN is low, immediately force indata1..7=0x00, slot_idx=0, entry_mag=0, entry_neg=0, error=0, done=0 and the FSM to IDLE, regardless of clk.
REQ-033 SHALL discard a partial entry when reset asserts mid-entry; no slot is written.

Structure
REQ-034 SHALL place NUM_SLOTS, MAX_DIGITS, the FSM state encodings and the limits POS_MAX=127 and NEG_MAX=128 in a shared package/header.
REQ-035 SHALL place the magnitude*10+digit datapath, digit counter and digit-overflow detect in one sub-module, bcd_digit_accumulator.

Verification
REQ-036 SHALL cover: digits 1,2,7 then enter -> indata1=0x7F next cycle, slot_idx=1, error=0.
REQ-037 SHALL cover: sign_toggle, digits 1,2,8, enter -> indata1=0x80; then positive 1,2,8 enter -> error=1, indata2=0x00, slot_idx stays 1.
REQ-038 SHALL cover: digits 1,2,3,4 -> entry_mag=123 with error=1; a digit 0xA strobe -> ignored, error stays 1.
REQ-039 SHALL cover: enter and digit_valid(5) in the same cycle -> only enter is serviced, and entry_mag=0 afterwards.
REQ-040 SHALL cover: seven commits of value 5 -> all indataN=0x05, done=1, slot_idx=7; further digits ignored; clear -> all zero, IDLE.
REQ-041 SHALL cover: digits 4,5 then resetN low mid-cycle -> all outputs 0 before the next clk edge, and no slot written.
